// File: rtl/arith_unit_32.sv
// arith_unit_32: combinational 32-bit adder, radix-4 Booth signed multiplier,
// and a 32-cycle restoring signed divider started by a synchronous reset.
module arith_unit_32 (
  input  logic        clk,
  input  logic        in_reset,
  input  logic [31:0] in_x,
  input  logic [31:0] in_y,
  input  logic        in_carry,
  output logic [31:0] out_sum,
  output logic        out_carry,
  output logic [63:0] out_product,
  output logic [31:0] out_quotient,
  output logic [31:0] out_remainder,
  output logic        out_div_done
);

  // Adder: plain 33-bit unsigned add; subtraction is done by the caller.
  always_comb begin
    {out_carry, out_sum} = {1'b0, in_x} + {1'b0, in_y} + {32'd0, in_carry};
  end

  // Multiplier: radix-4 Booth recoding of Y, 16 signed partial products of X.
  logic signed [63:0] mx, pp, acc;
  logic        [32:0] ye;
  logic        [2:0]  grp;
  always_comb begin
    mx  = {{32{in_x[31]}}, in_x};
    ye  = {in_y, 1'b0};
    acc = '0;
    pp  = '0;
    grp = '0;
    for (int i = 0; i < 16; i++) begin
      grp = ye[2*i +: 3];
      case (grp)
        3'b001, 3'b010: pp = mx;
        3'b011:         pp = mx <<< 1;
        3'b100:         pp = -(mx <<< 1);
        3'b101, 3'b110: pp = -mx;
        default:        pp = '0;
      endcase
      acc = acc + (pp <<< (2*i));
    end
    out_product = acc;
  end

  // Divider state: magnitudes, signs, shift registers and iteration count.
  logic [31:0] dvd, dvs, rem;
  logic        sx, sy, dz;
  logic [5:0]  cnt;

  // One restoring step: shift the next dividend bit into the partial remainder
  // and subtract the divisor if it fits.
  logic [32:0] sh, diff;
  logic [31:0] nrem, nq;
  always_comb begin
    sh   = {rem, dvd[31]};
    diff = sh - {1'b0, dvs};
    if (!diff[32]) begin
      nrem = diff[31:0];
      nq   = {dvd[30:0], 1'b1};
    end else begin
      nrem = sh[31:0];
      nq   = {dvd[30:0], 1'b0};
    end
  end

  // Load on reset, iterate while cnt < 32, publish sign-corrected result on
  // the final iteration; outputs stay zero until then and hold afterwards.
  always_ff @(posedge clk) begin
    if (in_reset) begin
      dvd           <= in_x[31] ? -in_x : in_x;
      dvs           <= in_y[31] ? -in_y : in_y;
      sx            <= in_x[31];
      sy            <= in_y[31];
      dz            <= (in_y == 32'd0);
      rem           <= '0;
      cnt           <= '0;
      out_quotient  <= '0;
      out_remainder <= '0;
      out_div_done  <= 1'b0;
    end else if (cnt < 6'd32) begin
      dvd <= nq;
      rem <= nrem;
      cnt <= cnt + 6'd1;
      if (cnt == 6'd31) begin
        // Divide by zero: quotient all ones; remainder naturally equals X.
        out_quotient  <= dz ? 32'hFFFF_FFFF : ((sx ^ sy) ? -nq : nq);
        out_remainder <= sx ? -nrem : nrem;
        out_div_done  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_arith_unit_32.sv
// Directed, table-driven bench for arith_unit_32.
module tb_arith_unit_32;
  logic        clk = 1'b0;
  logic        in_reset;
  logic [31:0] in_x, in_y;
  logic        in_carry;
  logic [31:0] out_sum;
  logic        out_carry;
  logic [63:0] out_product;
  logic [31:0] out_quotient, out_remainder;
  logic        out_div_done;

  int total = 0;
  int bad   = 0;

  arith_unit_32 dut (
    .clk(clk), .in_reset(in_reset), .in_x(in_x), .in_y(in_y),
    .in_carry(in_carry), .out_sum(out_sum), .out_carry(out_carry),
    .out_product(out_product), .out_quotient(out_quotient),
    .out_remainder(out_remainder), .out_div_done(out_div_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x, y;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
    logic [63:0] prod;
  } comb_vec_t;

  typedef struct {
    logic [31:0] x, y, q, r;
  } div_vec_t;

  comb_vec_t cv[8];
  div_vec_t  dv[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pulse reset with the operands, then run 32 edges checking that nothing
  // leaks early; operands are scrambled after the load edge.
  task automatic run_div(input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] q, input logic [31:0] r);
    @(negedge clk);
    in_reset = 1'b1; in_x = x; in_y = y;
    @(negedge clk);
    check("div_load_done", {63'd0, out_div_done}, 64'd0);
    in_reset = 1'b0;
    in_x = $urandom; in_y = $urandom;
    for (int e = 1; e <= 32; e++) begin
      @(negedge clk);
      if (e < 32) begin
        if (out_div_done !== 1'b0 || out_quotient !== 32'd0 || out_remainder !== 32'd0) begin
          check("div_early", {out_div_done, out_quotient, out_remainder[30:0]}, 64'd0);
        end
      end
    end
    check("div_done", {63'd0, out_div_done}, 64'd1);
    check("div_quot", {32'd0, out_quotient}, {32'd0, q});
    check("div_rem",  {32'd0, out_remainder}, {32'd0, r});
    repeat (3) @(negedge clk);
    check("div_hold", {out_quotient, out_remainder}, {q, r});
  endtask

  initial begin
    cv[0] = '{32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 64'h00000000_0000FFFF};
    cv[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 64'hFFFFFFFF_FFFFFFFF};
    cv[2] = '{32'h0000FFFF, 32'hFFFFFF00, 1'b1, 32'h0000FF00, 1'b1, 64'hFFFFFFFF_FF000100};
    cv[3] = '{32'hFFFFFFF3, 32'h0000000B, 1'b0, 32'hFFFFFFFE, 1'b0, 64'hFFFFFFFF_FFFFFF71};
    cv[4] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 64'h40000000_00000000};
    cv[5] = '{32'h00000007, 32'h00000006, 1'b0, 32'h0000000D, 1'b0, 64'h00000000_0000002A};
    cv[6] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 32'hFFFFFFFE, 1'b0, 64'h3FFFFFFF_00000001};
    cv[7] = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 32'h00000000, 1'b1, 64'hC0000000_80000000};

    dv[0] = '{32'd34,        32'd36,        32'd0,         32'd34};
    dv[1] = '{32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF};
    dv[2] = '{32'd7,         32'd0,         32'hFFFFFFFF,  32'd7};
    dv[3] = '{32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0};
    dv[4] = '{32'd100,       32'd7,         32'd14,        32'd2};
    dv[5] = '{32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1};
    dv[6] = '{32'hFFFFFFF9,  32'hFFFFFFFE,  32'd3,         32'hFFFFFFFF};
    dv[7] = '{32'hFFFFFFFB,  32'd0,         32'hFFFFFFFF,  32'hFFFFFFFB};

    in_reset = 1'b1; in_x = '0; in_y = '0; in_carry = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_quot", {32'd0, out_quotient}, 64'd0);
    check("rst_rem",  {32'd0, out_remainder}, 64'd0);
    check("rst_done", {63'd0, out_div_done}, 64'd0);

    // Combinational adder/multiplier vectors.
    for (int i = 0; i < 8; i++) begin
      in_x = cv[i].x; in_y = cv[i].y; in_carry = cv[i].cin;
      #1;
      check("add_sum",   {32'd0, out_sum}, {32'd0, cv[i].sum});
      check("add_carry", {63'd0, out_carry}, {63'd0, cv[i].cout});
      check("mul_prod",  out_product, cv[i].prod);
    end
    in_carry = 1'b0;

    // Sequential divide vectors.
    for (int i = 0; i < 8; i++) run_div(dv[i].x, dv[i].y, dv[i].q, dv[i].r);

    // Abort 100/7 at edge 10 and restart with 50/5.
    @(negedge clk);
    in_reset = 1'b1; in_x = 32'd100; in_y = 32'd7;
    @(negedge clk);
    in_reset = 1'b0;
    repeat (9) @(negedge clk);
    in_reset = 1'b1; in_x = 32'd50; in_y = 32'd5;
    @(negedge clk);
    check("abort_done", {63'd0, out_div_done}, 64'd0);
    in_reset = 1'b0;
    repeat (31) @(negedge clk);
    check("abort_early", {out_div_done, 31'd0, out_quotient}, 64'd0);
    @(negedge clk);
    check("abort_fin", {31'd0, out_div_done, out_quotient}, {32'd1, 32'd10});
    check("abort_rem", {32'd0, out_remainder}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/arith_unit_32.md
ARITH_UNIT_32 -- requirements
Module: arith_unit_32

Interface
Parameters: none; all widths are fixed at 32-bit operands.
REQ-001 The module SHALL have a single clock and a reset that is synchronous and active-high.
REQ-002 Port clk, input, 1 bit: single clock; all sequential state updates on the rising edge.
REQ-003 Port in_reset, input, 1 bit: synchronous active-high reset; also loads and starts the divider.
REQ-004 Port in_x, input, 32 bits: operand X (adder X, multiplicand, dividend).
REQ-005 Port in_y, input, 32 bits: operand Y (adder Y, multiplier, divisor).
REQ-006 Port in_carry, input, 1 bit: adder carry-in.
REQ-007 Port out_sum, output, 32 bits: adder sum.
REQ-008 Port out_carry, output, 1 bit: adder carry-out.
REQ-009 Port out_product, output, 64 bits: signed product.
REQ-010 Port out_quotient, output, 32 bits: signed quotient.
REQ-011 Port out_remainder, output, 32 bits: signed remainder.
REQ-012 Port out_div_done, output, 1 bit: the divider result is valid.

Function
REQ-013 The adder SHALL be combinational: {out_carry, out_sum} = in_x + in_y + in_carry, unsigned 33-bit result; subtraction is performed by the caller feeding ~Y with carry-in 1.
REQ-014 The multiplier SHALL be combinational: out_product = signed(in_x) * signed(in_y), full 64-bit two's-complement result, implemented as Booth bit-pair recoding, not the operator.
REQ-015 The divider SHALL be sequential: two's-complement signed division using a 32-iteration shift/subtract (restoring or non-restoring) datapath.
REQ-016 On any clock edge with in_reset=1 the divider SHALL do all of the following:
- latch |in_x|, |in_y| and both operand signs;
- clear the iteration counter;
- drive out_quotient=0, out_remainder=0, out_div_done=0.
REQ-017 Each edge with in_reset=0 and the counter below 32 SHALL perform exactly one iteration; operand changes after the load edge SHALL be ignored.
REQ-018 On the 32nd edge after reset deassertion, the divider SHALL register the sign-corrected quotient and remainder and set out_div_done=1.
REQ-019 After completion, the outputs SHALL hold until the next in_reset; with no reset, further edges SHALL NOT change them.
REQ-020 Sign rules:
- the quotient is truncated toward zero and is negative iff the operand signs differ;
- the remainder takes the sign of the dividend;
- the result satisfies X = Q*Y + R.
REQ-021 Divide by zero SHALL give out_quotient=32'hFFFFFFFF and out_remainder=in_x (as latched), with the same 32-cycle latency.
REQ-022 Overflow case 32'h80000000 / 32'hFFFFFFFF SHALL give quotient 32'h80000000 and remainder 0.
REQ-023 Asserting in_reset mid-division SHALL abort the division, reload the current operands and restart the 32-cycle count.
REQ-024 out_quotient and out_remainder SHALL remain 0 until out_div_done rises; no partial results shall be exposed.

Reset
REQ-025 The reset values SHALL be out_quotient=0, out_remainder=0, out_div_done=0 and the counter = 0.
REQ-026 The adder and multiplier outputs SHALL have no reset and SHALL always reflect the current inputs.

Verification
REQ-027 Add cases:
- in_x=0000FFFF, in_y=00000001, in_carry=0 -> out_sum=00010000, out_carry=0;
- in_x=FFFFFFFF, in_y=00000001 -> out_sum=0, out_carry=1.
REQ-028 Subtract: in_x=0000FFFF, in_y=FFFFFF00 (~000000FF), in_carry=1 -> out_sum=0000FF00, out_carry=1.
REQ-029 Multiply: in_x=FFFFFFF3, in_y=0000000B -> out_product=FFFFFFFF_FFFFFF71 (-143); in_x=in_y=80000000 -> 40000000_00000000.
REQ-030 Divide 34 / 36:
- in_reset pulsed high for one edge, then low;
- out_div_done=0 for edges 1-31;
- at edge 32: out_div_done=1, out_quotient=0, out_remainder=34.
REQ-031 Signed divide: -7 / 2 -> quotient FFFFFFFD, remainder FFFFFFFF; 7 / 0 -> quotient FFFFFFFF, remainder 7.
REQ-032 Reset mid-operation: start 100 / 7, reassert in_reset at edge 10 with in_x=50, in_y=5 -> done 32 edges after the new release, quotient 10, remainder 0.
